knn_bram_loader: RTL and testbench

- Write-side counterpart to the kNN datapath's BRAM read path.
- Accepts a word stream of training samples over a valid/ready handshake: FEATURES feature words, then one label word, per sample.
- Writes feature words into the data BRAM and label words into the label BRAM, at the addresses the datapath later reads.
- Signals done after the programmed sample count has been stored.

---
 rtl/knn_bram_loader.sv | 200 ++++++++++++++++++++
 tb/tb_knn_bram_loader.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_bram_loader.sv
// knn_bram_loader: writes a valid/ready stream of training samples (FEATURES feature words
// then one label word) into the kNN data and label BRAMs. LOADER_CHECKSUM_EN adds a running XOR checksum.
module knn_bram_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int FEATURES = 2,
  parameter int DEPTH    = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_samples,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en_data,
  output logic              wr_en_lab,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        dbg_state
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // Handshake: a word moves on any rising edge where in_valid && in_ready are both high.
  // in_ready depends on state only; in_valid may be asserted before in_ready and
  // in_data must be stable whenever in_valid is high.

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_DATA  = 2'd1,
    S_LOAD_LABEL = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  localparam int PW = 2 * ADDR_W + 2;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     num_lat;
  logic [ADDR_W-1:0]   data_ptr;
  logic [ADDR_W-1:0]   feat_cnt;
  logic [ADDR_W-1:0]   sample_cnt;

  logic [PW-1:0]       need_words;
  logic                cap_ok;
  logic                xfer;
  logic                feat_last;
  logic                sample_last;

  // Product is computed wide enough that num_samples*FEATURES can never overflow.
  assign need_words  = PW'(num_samples) * PW'(FEATURES);
  assign cap_ok      = (need_words <= PW'(DEPTH)) && (PW'(num_samples) <= PW'(DEPTH));
  assign xfer        = in_valid && in_ready;
  assign feat_last   = (feat_cnt == ADDR_W'(FEATURES - 1));
  assign sample_last = ({1'b0, sample_cnt} == (num_lat - (ADDR_W+1)'(1)));
  assign dbg_state   = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start && cap_ok) begin
          state_nxt = (num_samples == '0) ? S_DONE : S_LOAD_DATA;
        end
      end
      S_LOAD_DATA: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (xfer && feat_last) begin
          state_nxt = S_LOAD_LABEL;
        end
      end
      S_LOAD_LABEL: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (xfer) begin
          state_nxt = sample_last ? S_DONE : S_LOAD_DATA;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_LOAD_DATA, S_LOAD_LABEL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write port and counters; strobes default low so each transfer yields one pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en_data <= 1'b0;
      wr_en_lab  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      num_lat    <= '0;
      data_ptr   <= '0;
      feat_cnt   <= '0;
      sample_cnt <= '0;
      error      <= 1'b0;
    end else begin
      wr_en_data <= 1'b0;
      wr_en_lab  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cap_ok) begin
              num_lat    <= num_samples;
              data_ptr   <= '0;
              feat_cnt   <= '0;
              sample_cnt <= '0;
              error      <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD_DATA: begin
          if (abort) begin
            data_ptr   <= '0;
            feat_cnt   <= '0;
            sample_cnt <= '0;
          end else if (xfer) begin
            wr_en_data <= 1'b1;
            wr_addr    <= data_ptr;
            wr_data    <= in_data;
            data_ptr   <= data_ptr + ADDR_W'(1);
            feat_cnt   <= feat_last ? '0 : feat_cnt + ADDR_W'(1);
          end
        end
        S_LOAD_LABEL: begin
          if (abort) begin
            data_ptr   <= '0;
            feat_cnt   <= '0;
            sample_cnt <= '0;
          end else if (xfer) begin
            wr_en_lab  <= 1'b1;
            wr_addr    <= sample_cnt;
            wr_data    <= in_data;
            sample_cnt <= sample_cnt + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic accept_start;
  logic do_write;

  assign accept_start = (state == S_IDLE) && start && cap_ok;
  assign do_write     = xfer && !abort;

  // Folds in the word at the same edge that raises its strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept_start) begin
      checksum <= '0;
    end else if (do_write) begin
      checksum <= checksum ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_knn_bram_loader.sv
// Directed self-checking bench for knn_bram_loader (FEATURES=2, DEPTH=256).
// Checksum checks are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_knn_bram_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int REC_W  = 1 + ADDR_W + DATA_W;

  logic              clock;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_samples;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en_data;
  logic              wr_en_lab;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        dbg_state;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [REC_W-1:0]  obs_q[$];
  logic [REC_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] words_q[$];

  int cyc          = 0;
  int done_cnt     = 0;
  int rdy_cnt      = 0;
  int both_cnt     = 0;
  int done_cyc     = -1;
  int last_lab_cyc = -1;

  knn_bram_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FEATURES(2), .DEPTH(256)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .num_samples(num_samples),
    .abort(abort),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wr_en_data(wr_en_data),
    .wr_en_lab(wr_en_lab),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .error(error),
    .dbg_state(dbg_state)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  // ---------------- monitor: record strobes on the falling edge ----------------
  always @(negedge clock) begin
    cyc++;
    if (!reset) begin
      if (wr_en_data) obs_q.push_back({1'b0, wr_addr, wr_data});
      if (wr_en_lab) begin
        obs_q.push_back({1'b1, wr_addr, wr_data});
        last_lab_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_ready) rdy_cnt++;
      if (wr_en_data && wr_en_lab) both_cnt++;
    end
  end

  function automatic logic [REC_W-1:0] rec(input logic lab, input int addr, input logic [DATA_W-1:0] d);
    return {lab, ADDR_W'(addr), d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start_load(input int n);
    @(negedge clock);
    start       = 1'b1;
    num_samples = (ADDR_W+1)'(n);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Streams words_q starting at the current falling edge; toggle inserts a gap every other cycle.
  task automatic stream(input bit toggle);
    int idx   = 0;
    int guard = 0;
    bit gap   = 1'b0;
    while (idx < words_q.size() && guard < 3000) begin
      if (toggle && gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = words_q[idx];
      end
      if (in_valid && in_ready) idx++;
      gap = !gap;
      @(negedge clock);
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (idx != words_q.size()) begin
      n_fail++;
      $display("FAIL stream_accept: words accepted %0d, required %0d", idx, words_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({busy, in_ready, wr_en_data, wr_en_lab, done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000", {busy, in_ready, wr_en_data, wr_en_lab, done, error});
    end
    n_checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got addr %0h data %0h, required 0 0", wr_addr, wr_data);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got ready %b busy %b, required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_stream(input bit toggle, input string tag);
    int d0;
    int r0;
    logic [REC_W-1:0] hand[9];
    hand[0] = rec(0, 0, 32'h10); hand[1] = rec(0, 1, 32'h11); hand[2] = rec(1, 0, 32'h12);
    hand[3] = rec(0, 2, 32'h13); hand[4] = rec(0, 3, 32'h14); hand[5] = rec(1, 1, 32'h15);
    hand[6] = rec(0, 4, 32'h16); hand[7] = rec(0, 5, 32'h17); hand[8] = rec(1, 2, 32'h18);
    obs_q.delete(); exp_q.delete(); words_q.delete();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(hand[i]);
      words_q.push_back(32'h10 + i);
    end
    d0 = done_cnt; r0 = rdy_cnt; both_cnt = 0;
    start_load(3);
    stream(toggle);
    idle(3);
    n_checks++;
    if (obs_q.size() != 9) begin
      n_fail++;
      $display("FAIL %s_count: got %0d strobes, required 9", tag, obs_q.size());
    end
    for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_write[%0d]: got lab=%b addr=%0h data=%0h, required lab=%b addr=%0h data=%0h",
                 tag, i, obs_q[i][REC_W-1], obs_q[i][DATA_W +: ADDR_W], obs_q[i][DATA_W-1:0],
                 exp_q[i][REC_W-1], exp_q[i][DATA_W +: ADDR_W], exp_q[i][DATA_W-1:0]);
      end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt - d0);
    end
    n_checks++;
    if (done_cyc != last_lab_cyc) begin
      n_fail++;
      $display("FAIL %s_done_timing: done at cycle %0d, required cycle %0d (last label strobe)", tag, done_cyc, last_lab_cyc);
    end
    n_checks++;
    if (rdy_cnt - r0 != (toggle ? 17 : 9)) begin
      n_fail++;
      $display("FAIL %s_ready_cycles: got %0d, required %0d", tag, rdy_cnt - r0, toggle ? 17 : 9);
    end
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL %s_dual_strobe: got %0d, required 0", tag, both_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_end_idle: got busy %b state %0d, required 0 0", tag, busy, dbg_state);
    end
  endtask

  task automatic test_capacity();
    int k;
    int d0;
    obs_q.delete(); exp_q.delete(); words_q.delete();
    start_load(129);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL cap_reject: got error %b busy %b state %0d, required 1 0 0", error, busy, dbg_state);
    end
    idle(3);
    n_checks++;
    if (error !== 1'b1 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL cap_sticky: got error %b strobes %0d, required 1 0", error, obs_q.size());
    end
    k = 0;
    for (int s = 0; s < 128; s++) begin
      for (int f = 0; f < 2; f++) begin
        words_q.push_back(32'h1000 + k);
        exp_q.push_back(rec(0, s * 2 + f, 32'h1000 + k));
        k++;
      end
      words_q.push_back(32'h1000 + k);
      exp_q.push_back(rec(1, s, 32'h1000 + k));
      k++;
    end
    d0 = done_cnt;
    start_load(128);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_accept: got error %b busy %b, required 0 1", error, busy);
    end
    stream(1'b0);
    idle(3);
    n_checks++;
    if (obs_q.size() != 384) begin
      n_fail++;
      $display("FAIL cap_count: got %0d strobes, required 384", obs_q.size());
    end
    for (int i = 0; i < 384 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL cap_write[%0d]: got %0h, required %0h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() == 384) begin
      n_checks++;
      if (obs_q[382] !== rec(0, 255, 32'h1000 + 382)) begin
        n_fail++;
        $display("FAIL cap_last_data: got %0h, required addr ff data %0h", obs_q[382], 32'h1000 + 382);
      end
      n_checks++;
      if (obs_q[383] !== rec(1, 127, 32'h1000 + 383)) begin
        n_fail++;
        $display("FAIL cap_last_label: got %0h, required addr 7f data %0h", obs_q[383], 32'h1000 + 383);
      end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL cap_done: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_zero_samples();
    int d0;
    int r0;
    obs_q.delete();
    d0 = done_cnt; r0 = rdy_cnt;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    start_load(0);
    idle(3);
    in_valid = 1'b0;
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_done: got %0d pulses, required 1", done_cnt - d0);
    end
    n_checks++;
    if (rdy_cnt - r0 != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_quiet: got ready %0d strobes %0d, required 0 0", rdy_cnt - r0, obs_q.size());
    end
  endtask

  task automatic test_abort();
    int d0;
    obs_q.delete(); exp_q.delete(); words_q.delete();
    words_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    exp_q   = '{rec(0, 0, 32'hA0), rec(0, 1, 32'hA1), rec(1, 0, 32'hA2), rec(0, 2, 32'hA3)};
    d0 = done_cnt;
    start_load(3);
    stream(1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD;
    @(negedge clock);
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got state %0d busy %b ready %b, required 0 0 0", dbg_state, busy, in_ready);
    end
    idle(3);
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL abort_count: got %0d strobes, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_write[%0d]: got %0h, required %0h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    obs_q.delete();
    words_q = '{32'hB0, 32'hB1, 32'hB2};
    exp_q   = '{rec(0, 0, 32'hB0), rec(0, 1, 32'hB1), rec(1, 0, 32'hB2)};
    start_load(1);
    stream(1'b0);
    idle(3);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL restart_count: got %0d strobes, required 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_write[%0d]: got %0h, required %0h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    words_q.delete();
    words_q = '{32'hC0, 32'hC1};
    start_load(2);
    stream(1'b0);
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL midload_state: got %0d, required 2 (LOAD_LABEL)", dbg_state);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, in_ready, wr_en_data, wr_en_lab, done, error} !== 6'b0 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got flags %b addr %0h data %0h, required all 0",
               {busy, in_ready, wr_en_data, wr_en_lab, done, error}, wr_addr, wr_data);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midload_reset_state: got %0d, required 0", dbg_state);
    end
`ifdef LOADER_CHECKSUM_EN
    n_checks++;
    if (checksum !== '0) begin
      n_fail++;
      $display("FAIL midload_reset_checksum: got %0h, required 0", checksum);
    end
`endif
    @(negedge clock);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_checksum();
    obs_q.delete(); exp_q.delete(); words_q.delete();
    words_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    exp_q   = '{rec(0, 0, 32'd1), rec(0, 1, 32'd2), rec(1, 0, 32'd3),
                rec(0, 2, 32'd4), rec(0, 3, 32'd5), rec(1, 1, 32'd6)};
    start_load(2);
    stream(1'b0);
    idle(3);
    n_checks++;
    if (obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL cks_count: got %0d strobes, required 6", obs_q.size());
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL cks_write[%0d]: got %0h, required %0h", i, obs_q[i], exp_q[i]);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    n_checks++;
    if (checksum !== 32'h7) begin
      n_fail++;
      $display("FAIL checksum_value: got %0h, required 7", checksum);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_samples = '0;
    abort       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    idle(2);
    test_reset();
    test_stream(1'b0, "held");
    test_stream(1'b1, "toggle");
    test_capacity();
    test_zero_samples();
    test_abort();
    test_reset_mid_load();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
